ace_mem_ctrl: RTL and testbench



---
 rtl/ace_mem_pkg.sv | 27 ++
 rtl/ace_region_decode.sv | 40 ++++
 rtl/ace_mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ace_mem_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ace_mem_pkg.sv
// ace_mem_pkg: shared types and helpers for the Jupiter Ace memory-bus controller.
// Holds the controller state enum, the default data width and the slice helpers
// used to pull per-region base/mask/wait-state fields out of flattened parameters.
package ace_mem_pkg;

  localparam int ACE_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONTEND,
    ST_WAIT,
    ST_ACCESS,
    ST_DATA,
    ST_HOLD
  } ace_state_t;

  // Bit offset of field idx inside a flattened vector of width-bit fields.
  function automatic int field_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  // Width of a region index; never zero so a single region still gets a port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ace_region_decode.sv
// ace_region_decode: compares the CPU address against every region's base/mask
// pair and priority-encodes the result, lowest region index winning.
module ace_region_decode
  import ace_mem_pkg::*;
#(
  parameter int                     NREG     = 6,
  parameter int                     ADDR_W   = 16,
  parameter int                     SEL_W    = sel_width(NREG),
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = {NREG*ADDR_W{1'b0}},
  parameter logic [NREG*ADDR_W-1:0] REG_MASK = {NREG*ADDR_W{1'b1}}
) (
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [SEL_W-1:0]  sel,
  output logic              hit_any
);

  logic [NREG-1:0] hit_vec;

  // Per-region hit: masked address equals the region base.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      hit_vec[i] = ((cpu_addr & REG_MASK[field_lsb(i, ADDR_W) +: ADDR_W])
                    == REG_BASE[field_lsb(i, ADDR_W) +: ADDR_W]);
    end
  end

  // Priority encoder: scan from the top so the lowest hitting index is left last.
  always_comb begin
    sel     = '0;
    hit_any = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel     = SEL_W'(i);
        hit_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ace_mem_ctrl.sv
// ace_mem_ctrl: Z80-side memory-bus controller for the Jupiter Ace.
// Decodes the CPU address into one of NREG regions, sequences per-region wait
// states, pulses a one-cycle chip enable and registers the RAM read data back.
// Build option: define ACE_MEM_CONTEND_EN to enable the video-contention stall
// (CONTEND state, video_busy input and REG_CONTEND flags); without it the
// controller ignores video_busy entirely.
module ace_mem_ctrl
  import ace_mem_pkg::*;
#(
  parameter int                     NREG        = 6,
  parameter int                     ADDR_W      = 16,
  parameter int                     DATA_W      = ACE_DATA_W,
  parameter int                     WS_W        = 3,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE    = {NREG*ADDR_W{1'b0}},
  parameter logic [NREG*ADDR_W-1:0] REG_MASK    = {NREG*ADDR_W{1'b1}},
  parameter logic [NREG*WS_W-1:0]   REG_WS      = {NREG*WS_W{1'b0}},
  parameter logic [NREG-1:0]        REG_CONTEND = {NREG{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic                   mreq_n,
  input  logic                   wr_n,
  input  logic [DATA_W-1:0]      cpu_dout,
  output logic [DATA_W-1:0]      cpu_din,
  output logic                   data_oe,
  output logic                   wait_n,
  output logic [NREG-1:0]        region_ce,
  output logic                   region_we,
  input  logic [NREG*DATA_W-1:0] region_dout,
  input  logic                   video_busy,
  input  logic [DATA_W-1:0]      default_data
);

  localparam int SEL_W = sel_width(NREG);

  ace_state_t       state, next_state;
  logic [SEL_W-1:0] hit_sel, sel_q, sel_d;
  logic             hit_any;
  logic [WS_W-1:0]  ws_cnt, ws_d;
  logic             wr_q, wr_d;
  logic [DATA_W-1:0] din_d;
  logic             oe_d;
  logic             we_d;
  logic [NREG-1:0]  ce_d;
  logic             unused_bits;

  ace_region_decode #(
    .NREG     (NREG),
    .ADDR_W   (ADDR_W),
    .SEL_W    (SEL_W),
    .REG_BASE (REG_BASE),
    .REG_MASK (REG_MASK)
  ) u_decode (
    .cpu_addr (cpu_addr),
    .sel      (hit_sel),
    .hit_any  (hit_any)
  );

  // Write data goes from the CPU bus straight to the RAMs, so it is not used here.
`ifdef ACE_MEM_CONTEND_EN
  assign unused_bits = &{1'b0, cpu_dout};
`else
  assign unused_bits = &{1'b0, cpu_dout, video_busy, REG_CONTEND};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic plus the next value of every registered output.
  always_comb begin
    next_state = state;
    sel_d      = sel_q;
    ws_d       = ws_cnt;
    wr_d       = wr_q;
    din_d      = cpu_din;
    oe_d       = data_oe;
    ce_d       = '0;
    we_d       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!mreq_n) begin
          if (!hit_any) begin
            next_state = ST_HOLD;
            din_d      = default_data;
            oe_d       = 1'b0;
          end else begin
            sel_d      = hit_sel;
            ws_d       = REG_WS[field_lsb(int'(hit_sel), WS_W) +: WS_W];
            next_state = (ws_d != '0) ? ST_WAIT : ST_ACCESS;
`ifdef ACE_MEM_CONTEND_EN
            if (REG_CONTEND[hit_sel] && video_busy) next_state = ST_CONTEND;
`endif
          end
        end
      end
`ifdef ACE_MEM_CONTEND_EN
      ST_CONTEND: begin
        if (mreq_n) begin
          next_state = ST_IDLE;
          ws_d       = '0;
        end else if (!video_busy) begin
          next_state = (ws_cnt != '0) ? ST_WAIT : ST_ACCESS;
        end
      end
`endif
      ST_WAIT: begin
        if (mreq_n) begin
          next_state = ST_IDLE;
          ws_d       = '0;
        end else begin
          ws_d = ws_cnt - WS_W'(1);
          if (ws_cnt <= WS_W'(1)) next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: next_state = ST_DATA;
      ST_DATA: begin
        din_d      = region_dout[field_lsb(int'(sel_q), DATA_W) +: DATA_W];
        oe_d       = !wr_q;
        next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (mreq_n) begin
          next_state = ST_IDLE;
          oe_d       = 1'b0;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (next_state == ST_ACCESS) begin
      ce_d[sel_d] = 1'b1;
      we_d        = !wr_n;
      wr_d        = !wr_n;
    end
  end

  // Datapath and output registers; wait_n tracks the stall states directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= '0;
      ws_cnt    <= '0;
      wr_q      <= 1'b0;
      cpu_din   <= '0;
      data_oe   <= 1'b0;
      wait_n    <= 1'b1;
      region_ce <= '0;
      region_we <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      ws_cnt    <= ws_d;
      wr_q      <= wr_d;
      cpu_din   <= din_d;
      data_oe   <= oe_d;
      wait_n    <= !((next_state == ST_CONTEND) || (next_state == ST_WAIT));
      region_ce <= ce_d;
      region_we <= we_d;
    end
  end

endmodule

// File: tb/tb_ace_mem_ctrl.sv
// tb_ace_mem_ctrl: randomized self-checking bench for ace_mem_ctrl.
// Region map: 0 ROM 0000-1FFF, 1 screen 2000-23FF (ws1, contended),
// 2 char 2400-27FF, 3 0000-3FFF overlap (ws2), 4 4000-7FFF (ws3),
// 5 8000-BFFF (contended); C000-FFFF is unmapped.
module tb_ace_mem_ctrl;

  localparam int NREG = 6;

  localparam logic [NREG*16-1:0] P_BASE = {16'h8000, 16'h4000, 16'h0000, 16'h2400, 16'h2000, 16'h0000};
  localparam logic [NREG*16-1:0] P_MASK = {16'hC000, 16'hC000, 16'hC000, 16'hFC00, 16'hFC00, 16'hE000};
  localparam logic [NREG*3-1:0]  P_WS   = {3'd0, 3'd3, 3'd2, 3'd0, 3'd1, 3'd0};
  localparam logic [NREG-1:0]    P_CONT = 6'b100010;

`ifdef ACE_MEM_CONTEND_EN
  localparam bit CONTEND_EN = 1'b1;
`else
  localparam bit CONTEND_EN = 1'b0;
`endif

  // Reference region table, written out per region.
  logic [15:0] tb_base [NREG] = '{16'h0000, 16'h2000, 16'h2400, 16'h0000, 16'h4000, 16'h8000};
  logic [15:0] tb_mask [NREG] = '{16'hE000, 16'hFC00, 16'hFC00, 16'hC000, 16'hC000, 16'hC000};
  int          tb_ws   [NREG] = '{0, 1, 0, 2, 3, 0};
  bit          tb_cont [NREG] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       cpu_addr;
  logic              mreq_n;
  logic              wr_n;
  logic [7:0]        cpu_dout;
  logic [7:0]        cpu_din;
  logic              data_oe;
  logic              wait_n;
  logic [NREG-1:0]   region_ce;
  logic              region_we;
  logic [NREG*8-1:0] region_dout;
  logic              video_busy;
  logic [7:0]        default_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram       [NREG][256];
  logic [7:0] rd        [NREG];
  logic [7:0] mem_model [NREG][256];

  always #5 clk = ~clk;

  ace_mem_ctrl #(
    .NREG        (NREG),
    .ADDR_W      (16),
    .DATA_W      (8),
    .WS_W        (3),
    .REG_BASE    (P_BASE),
    .REG_MASK    (P_MASK),
    .REG_WS      (P_WS),
    .REG_CONTEND (P_CONT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .mreq_n       (mreq_n),
    .wr_n         (wr_n),
    .cpu_dout     (cpu_dout),
    .cpu_din      (cpu_din),
    .data_oe      (data_oe),
    .wait_n       (wait_n),
    .region_ce    (region_ce),
    .region_we    (region_we),
    .region_dout  (region_dout),
    .video_busy   (video_busy),
    .default_data (default_data)
  );

  // Synchronous RAMs with one cycle of read latency, old data on write.
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (region_ce[i]) begin
        rd[i] <= ram[i][cpu_addr[7:0]];
        if (region_we) ram[i][cpu_addr[7:0]] = cpu_dout;
      end
    end
  end

  always_comb begin
    region_dout = '0;
    for (int i = 0; i < NREG; i++) region_dout[i*8 +: 8] = rd[i];
  end

  function automatic int model_region(input logic [15:0] a);
    for (int i = 0; i < NREG; i++)
      if ((a & tb_mask[i]) == tb_base[i]) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s addr=%h: got %0h expected %0h", tag, cpu_addr, obs, exp);
    end
  endtask

  // One CPU bus cycle; abort_at>0 releases mreq_n after that many sampled cycles.
  task automatic applyStimulus(input logic [15:0] addr, input bit wr, input logic [7:0] wdata,
                               input int vb, input int abort_at, input logic [7:0] dflt);
    int r, stall, ws, extra, total;
    int wcnt, ce_cnt, ce_first, we_cnt, oe_first;
    logic [NREG-1:0] ce_seen;
    logic [7:0] din_at, exp_rd;
    r      = model_region(addr);
    stall  = (r >= 0 && CONTEND_EN && tb_cont[r] && vb > 0) ? vb : 0;
    ws     = (r >= 0) ? tb_ws[r] : 0;
    extra  = stall + ws;
    total  = extra + 6;
    exp_rd = (r >= 0) ? mem_model[r][addr[7:0]] : dflt;
    wcnt = 0; ce_cnt = 0; ce_first = 0; we_cnt = 0; oe_first = 0;
    ce_seen = '0; din_at = '0;
    @(negedge clk);
    cpu_addr = addr; wr_n = !wr; cpu_dout = wdata; default_data = dflt;
    mreq_n = 1'b0; video_busy = (vb > 0);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (!wait_n) wcnt++;
      if (region_ce != '0) begin
        ce_cnt++;
        ce_seen = ce_seen | region_ce;
        if (ce_first == 0) ce_first = c;
      end
      if (region_we) we_cnt++;
      if (data_oe && oe_first == 0) oe_first = c;
      if (c == extra + 3) din_at = cpu_din;
      if (abort_at != 0 && c == abort_at) mreq_n = 1'b1;
      if (c < vb)       video_busy = 1'b1;
      else if (c == vb) video_busy = 1'b0;
      else              video_busy = 1'($urandom_range(0, 1));
    end
    if (abort_at != 0) begin
      checkOutput("abort_ce_count", ce_cnt, 0);
      checkOutput("abort_we_count", we_cnt, 0);
      checkOutput("abort_wait_cycles", wcnt, abort_at);
      @(negedge clk);
      video_busy = 1'b0;
      checkOutput("abort_idle_wait_n", wait_n, 1);
    end else begin
      if (r < 0) begin
        checkOutput("nohit_ce_count", ce_cnt, 0);
        checkOutput("nohit_wait_cycles", wcnt, 0);
        checkOutput("nohit_oe", oe_first, 0);
        checkOutput("nohit_din", din_at, dflt);
      end else begin
        checkOutput("ce_count", ce_cnt, 1);
        checkOutput("ce_latency", ce_first, extra + 1);
        checkOutput("ce_onehot", ce_seen, 32'd1 << r);
        checkOutput("wait_cycles", wcnt, extra);
        checkOutput("we_count", we_cnt, wr ? 1 : 0);
        checkOutput("oe_latency", oe_first, wr ? 0 : extra + 3);
        if (!wr) checkOutput("read_data", din_at, exp_rd);
        if (wr) mem_model[r][addr[7:0]] = wdata;
      end
      @(negedge clk);
      mreq_n = 1'b1; video_busy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("release_oe", data_oe, 0);
      checkOutput("release_wait_n", wait_n, 1);
      if (r < 0)    checkOutput("hold_din_default", cpu_din, dflt);
      else if (!wr) checkOutput("hold_din", cpu_din, exp_rd);
    end
  endtask

  initial begin
    int a_r, e_r, ab;
    logic [15:0] ra;
    bit rw;
    int rvb;
    reset = 1'b1; cpu_addr = '0; mreq_n = 1'b1; wr_n = 1'b1; cpu_dout = '0;
    video_busy = 1'b0; default_data = 8'hFF;
    for (int i = 0; i < NREG; i++)
      for (int a = 0; a < 256; a++) begin
        logic [7:0] v;
        v = 8'($urandom);
        ram[i][a] = v;
        mem_model[i][a] = v;
      end
    ram[2][1] = 8'h5A; mem_model[2][1] = 8'h5A;

    repeat (3) @(negedge clk);
    checkOutput("reset_wait_n", wait_n, 1);
    checkOutput("reset_ce", region_ce, 0);
    checkOutput("reset_we", region_we, 0);
    checkOutput("reset_din", cpu_din, 0);
    checkOutput("reset_oe", data_oe, 0);
    reset = 1'b0;

    applyStimulus(16'h2401, 1'b0, 8'h00, 0, 0, 8'hFF);
    applyStimulus(16'h4000, 1'b0, 8'h00, 0, 0, 8'hFF);
    applyStimulus(16'h8000, 1'b0, 8'h00, 10, 0, 8'hFF);
    applyStimulus(16'h2000, 1'b0, 8'h00, 3, 0, 8'hFF);
    applyStimulus(16'h0000, 1'b0, 8'h00, 0, 0, 8'hFF);
    applyStimulus(16'hF000, 1'b0, 8'h00, 0, 0, 8'hFF);
    applyStimulus(16'h2800, 1'b1, 8'hC3, 0, 1, 8'hFF);
    applyStimulus(16'h2800, 1'b0, 8'h00, 0, 0, 8'hFF);
    applyStimulus(16'h2410, 1'b1, 8'h3C, 0, 0, 8'hFF);
    applyStimulus(16'h2410, 1'b0, 8'h00, 0, 0, 8'hFF);

    // Reset while the chip enable is out.
    @(negedge clk);
    cpu_addr = 16'h2401; wr_n = 1'b1; mreq_n = 1'b0; video_busy = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_ce", region_ce, 6'b000100);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_wait_n", wait_n, 1);
    checkOutput("midreset_ce", region_ce, 0);
    checkOutput("midreset_we", region_we, 0);
    checkOutput("midreset_din", cpu_din, 0);
    checkOutput("midreset_oe", data_oe, 0);
    mreq_n = 1'b1; reset = 1'b0;
    @(negedge clk);
    applyStimulus(16'h2401, 1'b0, 8'h00, 0, 0, 8'hFF);

    for (int t = 0; t < 45; t++) begin
      ra  = 16'($urandom_range(0, 65535));
      rw  = 1'($urandom_range(0, 1));
      rvb = $urandom_range(0, 4);
      a_r = model_region(ra);
      e_r = (a_r >= 0) ? tb_ws[a_r] + ((CONTEND_EN && tb_cont[a_r] && rvb > 0) ? rvb : 0) : 0;
      ab  = (e_r > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, e_r) : 0;
      applyStimulus(ra, rw, 8'($urandom), rvb, ab, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
